shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer.sv | 119 +++++++++++
 tb/tb_shift_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: drives an n-bit right-shift register through one parallel
// load, then exactly n shift cycles. The second word is fed into sin LSB first.
// The bits leaving sout are reassembled into the captured register.
// Handshake: start (sampled in IDLE only), busy (LOAD/SHIFT), done (one cycle).
// Optional feature macro: SEQ_ABORT_EN adds an abort input that returns
// LOAD/SHIFT straight to IDLE without a done pulse.
module shift_sequencer #(
  parameter int n     = 5,
  parameter int CNT_W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] load_val,
  input  logic [n-1:0] ser_val,
  input  logic         sout_in,
`ifdef SEQ_ABORT_EN
  input  logic         abort,
`endif
  output logic         ldQ,
  output logic         shQ,
  output logic         sin,
  output logic [n-1:0] qin,
  output logic [n-1:0] captured,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Counter value during the last of the n shift cycles.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(n - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [n-1:0]     r_qin;
  logic [n-1:0]     r_ser;
  logic [n-1:0]     r_captured;
  logic             w_abort;

`ifdef SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode.
  // NOTE: w_next gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    w_next = w_abort ? IDLE : SHIFT;
      SHIFT: begin
        if (w_abort)                w_next = IDLE;
        else if (r_cnt == LAST_CNT) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: latch the words on acceptance, then shift and capture in SHIFT.
  // On an abort edge in SHIFT the shift still completes, so captured keeps
  // the partial value.
  // NOTE: these are plain registers, not a memory, so all of them reset and
  // the outputs are 0 immediately while rst is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_qin      <= '0;
      r_ser      <= '0;
      r_captured <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_qin      <= load_val;
            r_ser      <= ser_val;
            r_captured <= '0;
          end
        end
        LOAD: r_cnt <= '0;
        SHIFT: begin
          r_ser      <= r_ser >> 1;
          r_captured <= {sout_in, r_captured[n-1:1]};
          // Hold the counter at or below n-1 so it never wraps.
          r_cnt      <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Moore control outputs, decoded from the state register only.
  assign ldQ      = (r_state == LOAD);
  assign shQ      = (r_state == SHIFT);
  assign busy     = (r_state == LOAD) || (r_state == SHIFT);
  assign done     = (r_state == DONE);
  assign sin      = (r_state == SHIFT) && r_ser[0];
  assign qin      = r_qin;
  assign captured = r_captured;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer. It models the downstream right-shift register.
// A queue holds the expected {captured, register content} for each sequence.
// Entries are pushed when start is driven and popped in the done cycle.
module tb_shift_sequencer;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] load_val;
  logic [N-1:0] ser_val;
  logic         sout_in;
`ifdef SEQ_ABORT_EN
  logic         abort;
`endif
  logic         ldQ;
  logic         shQ;
  logic         sin;
  logic [N-1:0] qin;
  logic [N-1:0] captured;
  logic         busy;
  logic         done;

  shift_sequencer #(.n(N), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .load_val (load_val),
    .ser_val  (ser_val),
    .sout_in  (sout_in),
`ifdef SEQ_ABORT_EN
    .abort    (abort),
`endif
    .ldQ      (ldQ),
    .shQ      (shQ),
    .sin      (sin),
    .qin      (qin),
    .captured (captured),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Downstream n-bit right-shift register driven by the sequencer.
  logic [N-1:0] sr;
  always @(posedge clk or posedge rst) begin
    if (rst)      sr <= '0;
    else if (ldQ) sr <= qin;
    else if (shQ) sr <= {sin, sr[N-1:1]};
  end
  assign sout_in = sr[0];

  typedef struct packed {
    logic [N-1:0] cap;
    logic [N-1:0] q;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Control vector {ldQ, shQ, busy, done}.
  task automatic check_ctl(input string tag, input logic [3:0] expv);
    check(tag, 32'({ldQ, shQ, busy, done}), 32'(expv));
  endtask

  // Runs one full sequence. The caller must be at a negedge in IDLE.
  // The task returns at the negedge of the DONE cycle.
  // With hold set, start stays high for the whole sequence.
  // With scramble set, the inputs change to lv2/sv2 after latching.
  task automatic run_seq(input logic [N-1:0] lv, input logic [N-1:0] sv,
                         input bit hold, input bit scramble,
                         input logic [N-1:0] lv2, input logic [N-1:0] sv2);
    exp_t e;
    load_val = lv;
    ser_val  = sv;
    start    = 1'b1;
    sb.push_back('{cap: lv, q: sv});
    @(negedge clk);
    if (!hold) start = 1'b0;
    check_ctl("load.ctl", 4'b1010);
    check("load.qin", 32'(qin), 32'(lv));
    check("load.cap_clear", 32'(captured), 32'(0));
    check("load.sin", 32'(sin), 32'(0));
    if (scramble) begin
      load_val = lv2;
      ser_val  = sv2;
    end
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check_ctl("shift.ctl", 4'b0110);
      check("shift.sin", 32'(sin), 32'(sv[i]));
      check("shift.qin", 32'(qin), 32'(lv));
    end
    @(negedge clk);
    check_ctl("done.ctl", 4'b0001);
    check("done.sin", 32'(sin), 32'(0));
    check("sb.nonempty", 32'(sb.size() != 0), 32'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("done.captured", 32'(captured), 32'(e.cap));
      check("done.qout", 32'(sr), 32'(e.q));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] exp_cap;
    rst      = 1'b1;
    start    = 1'b0;
    load_val = '0;
    ser_val  = '0;
`ifdef SEQ_ABORT_EN
    abort    = 1'b0;
`endif

    // 1. Reset state, then three idle cycles.
    #2;
    check("rst.outs", 32'({ldQ, shQ, sin, busy, done}), 32'(0));
    check("rst.qin", 32'(qin), 32'(0));
    check("rst.captured", 32'(captured), 32'(0));
    #8 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_ctl("idle.ctl", 4'b0000);
    end

    // 2. Basic sequence.
    run_seq(5'b10110, 5'b01101, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check_ctl("post2.ctl", 4'b0000);
    check("post2.captured_hold", 32'(captured), 32'(5'b10110));
    @(negedge clk);
    check("post2.captured_hold2", 32'(captured), 32'(5'b10110));

    // 3. Start held high. Input changes mid-sequence are ignored.
    //    Start in DONE is ignored, and the next start is taken after DONE.
    run_seq(5'b11001, 5'b00110, 1'b1, 1'b1, 5'b01010, 5'b10011);
    @(negedge clk);
    check_ctl("held.idle_after_done", 4'b0000);
    run_seq(5'b01010, 5'b10011, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check_ctl("held.idle", 4'b0000);

    // 4. Reset during the third shift cycle.
    load_val = 5'b11100;
    ser_val  = 5'b00101;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check_ctl("rstmid.pre", 4'b0110);
    #1 rst = 1'b1;
    #1;
    check("rstmid.outs", 32'({ldQ, shQ, sin, busy, done}), 32'(0));
    check("rstmid.qin", 32'(qin), 32'(0));
    check("rstmid.captured", 32'(captured), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_ctl("rstmid.nodone", 4'b0000);
    end
    run_seq(5'b11100, 5'b00101, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check_ctl("rstmid.idle", 4'b0000);

    // 5. Back-to-back: start in the cycle right after DONE.
    run_seq(5'b00001, 5'b11111, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check_ctl("b2b.idle", 4'b0000);
    check("b2b.captured_hold", 32'(captured), 32'(5'b00001));

    // 6. Abort on the second shift cycle, or a plain run without the macro.
`ifdef SEQ_ABORT_EN
    load_val = 5'b10110;
    ser_val  = 5'b01101;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_ctl("abort.shift2", 4'b0110);
    abort = 1'b1;
    @(negedge clk);
    abort   = 1'b0;
    exp_cap = {load_val[1], load_val[0], 3'b000};
    check_ctl("abort.after", 4'b0000);
    check("abort.captured", 32'(captured), 32'(exp_cap));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_ctl("abort.nodone", 4'b0000);
      check("abort.captured_hold", 32'(captured), 32'(exp_cap));
    end
    // Start and abort together in IDLE: start wins.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_ctl("abort.start_wins", 4'b1010);
    for (int i = 0; i < N; i++) @(negedge clk);
    @(negedge clk);
    check_ctl("abort.rerun_done", 4'b0001);
    check("abort.rerun_captured", 32'(captured), 32'(5'b10110));
    check("abort.rerun_qout", 32'(sr), 32'(5'b01101));
`else
    exp_cap = 5'b10110;
    run_seq(exp_cap, 5'b01101, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check_ctl("noabort.idle", 4'b0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
